// File: rtl/adc_spi_pkg.sv
// Shared types and constants for the ADC SPI sampler.
package adc_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2
  } adc_spi_state_t;

  localparam int OVR_CNT_W = 16;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adc_sample_timer.sv
// Enable-gated sample-period counter; tick is a registered one-cycle pulse
// so the first tick lands SAMPLE_PERIOD cycles after en is first sampled.
module adc_sample_timer
  import adc_spi_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 80
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int TW = cnt_w(SAMPLE_PERIOD);

  logic [TW-1:0] timer;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (!en) begin
        timer <= '0;
      end else if (timer == TW'(SAMPLE_PERIOD - 1)) begin
        timer <= '0;
        tick  <= 1'b1;
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_spi_sampler.sv
// Periodic SPI-master front end for the beacon ADC with a valid/ready sample
// output. Optional ADC_SPI_OVERRUN_CNT_EN adds a saturating overrun counter.
module adc_spi_sampler
  import adc_spi_pkg::*;
#(
  parameter int SCLK_DIV      = 4,
  parameter int FRAME_BITS    = 16,
  parameter int SAMPLE_BITS   = 12,
  parameter int SAMPLE_PERIOD = 80
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  output logic                   adc_cs_n,
  output logic                   adc_sclk,
  input  logic                   adc_miso,
  output logic [SAMPLE_BITS-1:0] sample_data,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic                   overrun
`ifdef ADC_SPI_OVERRUN_CNT_EN
  ,
  output logic [OVR_CNT_W-1:0]   overrun_count
`endif
);

  localparam int H     = SCLK_DIV / 2;
  localparam int PH_W  = cnt_w(H);
  localparam int BIT_W = cnt_w(FRAME_BITS);

  if (SCLK_DIV < 2 || (SCLK_DIV % 2) != 0) begin : g_bad_div
    $error("adc_spi_sampler: SCLK_DIV must be even and >= 2");
  end
  if (SAMPLE_BITS < 1 || SAMPLE_BITS > FRAME_BITS) begin : g_bad_bits
    $error("adc_spi_sampler: SAMPLE_BITS must be in 1..FRAME_BITS");
  end
  if (SAMPLE_PERIOD < H + FRAME_BITS * SCLK_DIV + 2) begin : g_bad_period
    $error("adc_spi_sampler: SAMPLE_PERIOD too short for one frame");
  end

  adc_spi_state_t         state;
  logic [PH_W-1:0]        ph;
  logic [BIT_W-1:0]       bit_idx;
  logic [SAMPLE_BITS-1:0] shreg;
  logic                   tick;
  logic                   ph_last;
  logic                   frame_done;

  adc_sample_timer #(.SAMPLE_PERIOD(SAMPLE_PERIOD)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .tick  (tick)
  );

  assign ph_last    = (ph == PH_W'(H - 1));
  // Last high phase of the last bit: cs_n releases on the same edge.
  assign frame_done = (state == SHIFT) && ph_last && adc_sclk &&
                      (bit_idx == BIT_W'(FRAME_BITS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ph       <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      adc_cs_n <= 1'b1;
      adc_sclk <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          adc_cs_n <= 1'b1;
          adc_sclk <= 1'b1;
          if (tick) begin
            state    <= SETUP;
            adc_cs_n <= 1'b0;
            ph       <= '0;
          end
        end
        SETUP: begin
          if (ph_last) begin
            state    <= SHIFT;
            ph       <= '0;
            bit_idx  <= '0;
            adc_sclk <= 1'b0;
          end else begin
            ph <= ph + 1'b1;
          end
        end
        SHIFT: begin
          if (!ph_last) begin
            ph <= ph + 1'b1;
          end else begin
            ph <= '0;
            if (!adc_sclk) begin
              // Rising SCLK edge: the ADC has held this bit for a full low phase.
              adc_sclk <= 1'b1;
              shreg    <= (shreg << 1) | SAMPLE_BITS'(adc_miso);
            end else if (frame_done) begin
              state    <= IDLE;
              adc_cs_n <= 1'b1;
            end else begin
              adc_sclk <= 1'b0;
              bit_idx  <= bit_idx + 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          adc_cs_n <= 1'b1;
          adc_sclk <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_data  <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (frame_done) begin
        // A same-cycle accept frees the slot, so the new sample still lands.
        if (!sample_valid || sample_ready) begin
          sample_data  <= shreg;
          sample_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

`ifdef ADC_SPI_OVERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun_count <= '0;
    end else if (overrun && (overrun_count != '1)) begin
      overrun_count <= overrun_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Directed bench for adc_spi_sampler at default parameters, with a simple
// MSB-first ADC model driving adc_miso from the frame word.
module tb_adc_spi_sampler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic        adc_miso = 1'b0;
  logic [11:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        overrun;
`ifdef ADC_SPI_OVERRUN_CNT_EN
  logic [15:0] overrun_count;
`endif

  int          vectors = 0;
  int          errors  = 0;
  int          cyc     = 0;
  int          falls   = 0;
  int          ovr_seen = 0;
  int          nbit    = 0;
  logic        prev_sclk = 1'b1;
  logic [15:0] frame   = 16'h0000;

  adc_spi_sampler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .adc_cs_n     (adc_cs_n),
    .adc_sclk     (adc_sclk),
    .adc_miso     (adc_miso),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun)
`ifdef ADC_SPI_OVERRUN_CNT_EN
    ,
    .overrun_count(overrun_count)
`endif
  );

  always #5 clk = ~clk;

  // ADC model: presents frame[15] at cs_n fall, advances one bit per SCLK rise.
  always @(posedge clk) begin
    #2;
    if (adc_cs_n) nbit = 0;
    else if (adc_sclk && !prev_sclk) nbit++;
    if (prev_sclk && !adc_sclk) falls++;
    if (overrun) ovr_seen++;
    prev_sclk = adc_sclk;
    adc_miso  = (nbit < 16) ? frame[15 - nbit] : 1'b0;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_low(input string tag);
    int n = 0;
    while (adc_cs_n === 1'b1 && n < 400) begin step(1); n++; end
    chk(tag, {31'b0, adc_cs_n}, 32'd0);
  endtask

  task automatic wait_high(input string tag);
    int n = 0;
    while (adc_cs_n === 1'b0 && n < 400) begin step(1); n++; end
    chk(tag, {31'b0, adc_cs_n}, 32'd1);
  endtask

  initial begin
    int n, lowcnt, t1, t2;
    logic stayed;

    rst_n = 1'b0; en = 1'b0; sample_ready = 1'b0;
    step(3);
    chk("rst_cs_n", adc_cs_n, 1);
    chk("rst_sclk", adc_sclk, 1);
    chk("rst_valid", sample_valid, 0);
    chk("rst_data", sample_data, 0);
    chk("rst_overrun", overrun, 0);
`ifdef ADC_SPI_OVERRUN_CNT_EN
    chk("rst_ovr_count", overrun_count, 0);
`endif
    rst_n = 1'b1;
    step(2);

    // First conversion: latency, frame length, SCLK edges, captured sample.
    frame = 16'h0ABC; falls = 0; en = 1'b1;
    n = 0;
    while (adc_cs_n === 1'b1 && n < 300) begin step(1); n++; end
    chk("cs_fall_latency", n, 81);
    lowcnt = 1;
    while (adc_cs_n === 1'b0 && lowcnt < 300) begin
      step(1);
      if (adc_cs_n === 1'b0) lowcnt++;
    end
    chk("cs_low_cycles", lowcnt, 66);
    chk("sclk_falls", falls, 16);
    chk("first_data", sample_data, 12'hABC);
    chk("first_valid", sample_valid, 1);
    chk("sclk_idle_high", adc_sclk, 1);

    // Ready held high: two samples accepted, 80 cycles apart, no overrun.
    sample_ready = 1'b1; ovr_seen = 0;
    step(1);
    chk("accept_clears_valid", sample_valid, 0);
    frame = 16'h0123;
    wait_low("f123_start"); wait_high("f123_end");
    t1 = cyc;
    chk("f123_data", sample_data, 12'h123);
    chk("f123_valid", sample_valid, 1);
    frame = 16'h0FFF;
    wait_low("ffff_start"); wait_high("ffff_end");
    t2 = cyc;
    chk("fff_data", sample_data, 12'hFFF);
    chk("sample_spacing", t2 - t1, 80);
    chk("no_overrun_streaming", ovr_seen, 0);
    step(1);

    // Ready held low across two frames: first kept, one overrun pulse.
    sample_ready = 1'b0;
    frame = 16'h0555;
    wait_low("f555_start"); wait_high("f555_end");
    chk("f555_data", sample_data, 12'h555);
    ovr_seen = 0;
    frame = 16'h0AAA;
    wait_low("faaa_start"); wait_high("faaa_end");
    chk("overrun_pulse", overrun, 1);
    chk("overrun_keeps_data", sample_data, 12'h555);
    chk("overrun_keeps_valid", sample_valid, 1);
    step(1);
    chk("overrun_one_cycle", overrun, 0);
    chk("overrun_count_pulses", ovr_seen, 1);
`ifdef ADC_SPI_OVERRUN_CNT_EN
    chk("overrun_count", overrun_count, 1);
`endif

    // Completion coincides with accept of the held sample.
    frame = 16'h0777;
    wait_low("f777_start");
    step(65);
    chk("f777_still_low", adc_cs_n, 0);
    sample_ready = 1'b1;
    step(1);
    chk("f777_cs_high", adc_cs_n, 1);
    chk("f777_data", sample_data, 12'h777);
    chk("f777_valid", sample_valid, 1);
    chk("f777_no_overrun", overrun, 0);
    sample_ready = 1'b0;
    step(1);
    chk("f777_held_valid", sample_valid, 1);

    // en dropped 10 cycles into SHIFT: frame completes, no further ticks.
    sample_ready = 1'b1;
    step(1);
    frame = 16'h0321;
    wait_low("f321_start");
    step(12);
    en = 1'b0;
    wait_high("f321_end");
    chk("f321_data", sample_data, 12'h321);
    chk("f321_valid", sample_valid, 1);
    sample_ready = 1'b0;
    stayed = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (adc_cs_n !== 1'b1) stayed = 1'b0;
    end
    chk("idle_after_en_drop", stayed, 1);
    chk("f321_held", sample_data, 12'h321);

    // Reset mid-SHIFT, then restart latency from release.
    frame = 16'h0BEE; en = 1'b1;
    wait_low("pre_rst_start");
    step(10);
    rst_n = 1'b0;
    step(1);
    chk("midrst_cs_n", adc_cs_n, 1);
    chk("midrst_sclk", adc_sclk, 1);
    chk("midrst_valid", sample_valid, 0);
    chk("midrst_data", sample_data, 0);
    step(4);
    rst_n = 1'b1;
    n = 0;
    while (adc_cs_n === 1'b1 && n < 300) begin step(1); n++; end
    chk("restart_latency", n, 81);
    wait_high("fbee_end");
    chk("fbee_data", sample_data, 12'hBEE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
